jht_update_queue: RTL and testbench
===================================

# jht_update_queue

Execute-side writer for the jump history table. It accepts resolved j/jal jumps from EXE and compares each one against the prediction carried down from F1. On a wrong or missing prediction it raises a one-cycle redirect to fetch. It buffers the required table writes in a small FIFO and drains them one per cycle through a valid/ready handshake into the table's replace-port write interface.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- Derived: PTR_BITS = $clog2(DEPTH); CNT_BITS = $clog2(DEPTH+1)

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- exe_valid  in  1  EXE holds a resolved j/jal this cycle
- exe_pc  in  32  pc of the resolved jump
- exe_dest  in  32  actual jump target
- exe_pred_hit  in  1  F1 table hit for this jump, pipelined to EXE
- exe_pred_pc  in  32  F1 predicted target, pipelined to EXE
- exe_ready  out  1  queue can accept; EXE stalls while exe_valid && !exe_ready
- mispredict  out  1  registered one-cycle redirect pulse
- redirect_pc  out  32  correct target; meaningful when mispredict=1
- upd_valid  out  1  head entry presented to the table
- upd_pc  out  32  head entry jump pc (table executed_j_pc)
- upd_dest  out  32  head entry target (table dest_pc)
- upd_ready  in  1  table write port free this cycle
- stat_resolved  out  32  accepted-jump counter (see Configuration)
- stat_mispredict  out  32  mispredict counter (see Configuration)

## Operation
- accept = exe_valid && exe_ready; exe_ready = (count != DEPTH). A dequeue in the same cycle does not free a slot for acceptance.
- correct = exe_pred_hit && (exe_pred_pc == exe_dest).
- On accept && !correct:
  - mispredict <= 1
  - redirect_pc <= exe_dest
  - the entry is enqueued unless it is a duplicate
- On accept && correct: no enqueue and no redirect. The table already holds the right target.
- Duplicate: count != 0 and the youngest resident entry (slot tail-1 mod DEPTH) has an identical pc and dest. A duplicate is dropped, but the mispredict is still raised. This holds even if that entry is dequeuing in the same cycle.
- Dequeue = upd_valid && upd_ready. The head advances and count decrements.
- upd_valid = (count != 0). upd_pc and upd_dest are read directly from the head slot.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. count spans 0..DEPTH.
- Entries are never flushed. A resolved jump is architectural, so pipeline flushes do not affect the queue.

## Timing
- Reset, asynchronous on resetn=0:
  - head = tail = count = 0
  - mispredict = 0, redirect_pc = 0
  - upd_valid = 0, exe_ready = 1
  - stat counters = 0
  - Reset asserted mid-drain discards all entries immediately.
- Accept at edge N:
  - the entry is visible on upd_* after edge N, a 1-cycle minimum latency
  - mispredict is high for exactly the cycle after edge N
- Back-to-back mispredicting accepts produce back-to-back mispredict pulses, each carrying its own redirect_pc.
- upd_* are stable while upd_valid && !upd_ready.
- Full: exe_ready=0 from the cycle count reaches DEPTH until the edge after the first dequeue.

## Configuration
- JHT_UQ_STATS_EN defined:
  - stat_resolved increments on every accept
  - stat_mispredict increments on every accept && !correct
  - both counters saturate at 32'hFFFF_FFFF
  - both are reset by resetn
- JHT_UQ_STATS_EN undefined: both stat ports are tied to 0 and no counter flops exist. All other behaviour is identical.

## Test plan
- Reset, then accept pc=0x8000_0010, dest=0x8000_0400, pred_hit=0 -> next cycle:
  - mispredict=1, redirect_pc=0x8000_0400
  - upd_valid=1, upd_pc=0x8000_0010, upd_dest=0x8000_0400
  - with upd_ready=1, count returns to 0 after one cycle.
- Accept with pred_hit=1 and pred_pc=dest=0x8000_0400 -> mispredict stays 0 and upd_valid stays 0.
- upd_ready=0 with 4 distinct mispredicting jumps -> exe_ready drops after the 4th accept; a 5th jump stalls. Raise upd_ready -> entries drain in FIFO order; exe_ready returns high on the edge after the first dequeue.
- Two consecutive identical mispredicting jumps (pc=0x8000_0020, dest=0x8000_0800) with upd_ready=0 -> two mispredict pulses but only one entry (count=1).
- Assert resetn=0 asynchronously mid-cycle with 3 entries queued -> upd_valid=0 and exe_ready=1 immediately, before the next clock edge.
- With JHT_UQ_STATS_EN: 5 accepts, 2 of them mispredicting -> stat_resolved=5, stat_mispredict=2. Without the macro -> both read 0.

Source files
------------

// File: rtl/jht_update_queue_if.sv
// rtl/jht_update_queue_if.sv - EXE-side and table-side handshake bundle for the jump history update queue
interface jht_update_queue_if;
   logic        exe_valid;
   logic [31:0] exe_pc;
   logic [31:0] exe_dest;
   logic        exe_pred_hit;
   logic [31:0] exe_pred_pc;
   logic        exe_ready;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [31:0] upd_dest;
   logic        upd_ready;

   // queue side: consumes resolved jumps, produces table writes
   modport master (
      input  exe_valid, exe_pc, exe_dest, exe_pred_hit, exe_pred_pc,
      output exe_ready,
      output upd_valid, upd_pc, upd_dest,
      input  upd_ready
   );

   // environment side: EXE stage and the table write port
   modport slave (
      output exe_valid, exe_pc, exe_dest, exe_pred_hit, exe_pred_pc,
      input  exe_ready,
      input  upd_valid, upd_pc, upd_dest,
      output upd_ready
   );
endinterface

// File: rtl/jht_update_queue.sv
// rtl/jht_update_queue.sv - jump history table writer with mispredict redirect; optional stats via JHT_UQ_STATS_EN
module jht_update_queue #(
   parameter int DEPTH = 4
) (
   input  logic                clk,
   input  logic                resetn,
   jht_update_queue_if.master  q,
   output logic                mispredict,
   output logic [31:0]         redirect_pc,
   output logic [31:0]         stat_resolved,
   output logic [31:0]         stat_mispredict
);
   localparam int PTR_BITS = $clog2(DEPTH);
   localparam int CNT_BITS = $clog2(DEPTH + 1);

   logic [PTR_BITS-1:0] head;
   logic [PTR_BITS-1:0] tail;
   logic [PTR_BITS-1:0] tail_prev;
   logic [CNT_BITS-1:0] count;
   logic [31:0]         pc_mem   [DEPTH];
   logic [31:0]         dest_mem [DEPTH];

   logic accept;
   logic correct;
   logic duplicate;
   logic enq;
   logic deq;

   // Slot freed by a same-cycle dequeue is not offered to EXE until the next cycle.
   assign q.exe_ready = (count != CNT_BITS'(DEPTH));
   assign q.upd_valid = (count != '0);
   assign q.upd_pc    = pc_mem[head];
   assign q.upd_dest  = dest_mem[head];

   assign accept    = q.exe_valid && q.exe_ready;
   assign correct   = q.exe_pred_hit && (q.exe_pred_pc == q.exe_dest);
   assign tail_prev = tail - PTR_BITS'(1);
   // Youngest entry is compared even if it is leaving this cycle; the table gets it anyway.
   assign duplicate = (count != '0) && (pc_mem[tail_prev] == q.exe_pc)
                                    && (dest_mem[tail_prev] == q.exe_dest);
   assign enq       = accept && !correct && !duplicate;
   assign deq       = q.upd_valid && q.upd_ready;

   // Entry storage: written at the tail on enqueue, no reset needed.
   always_ff @(posedge clk) begin
      if (enq) begin
         pc_mem[tail]   <= q.exe_pc;
         dest_mem[tail] <= q.exe_dest;
      end
   end

   // Pointers, occupancy and the one-cycle redirect pulse.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         mispredict  <= 1'b0;
         redirect_pc <= '0;
      end else begin
         if (enq) tail <= tail + PTR_BITS'(1);
         if (deq) head <= head + PTR_BITS'(1);
         case ({enq, deq})
            2'b10:   count <= count + CNT_BITS'(1);
            2'b01:   count <= count - CNT_BITS'(1);
            default: count <= count;
         endcase
         mispredict <= accept && !correct;
         if (accept && !correct) redirect_pc <= q.exe_dest;
      end
   end

`ifdef JHT_UQ_STATS_EN
   // Saturating accepted-jump and mispredict counters.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stat_resolved   <= '0;
         stat_mispredict <= '0;
      end else begin
         if (accept && (stat_resolved != 32'hFFFF_FFFF))
            stat_resolved <= stat_resolved + 32'd1;
         if (accept && !correct && (stat_mispredict != 32'hFFFF_FFFF))
            stat_mispredict <= stat_mispredict + 32'd1;
      end
   end
`else
   assign stat_resolved   = '0;
   assign stat_mispredict = '0;
`endif
endmodule

// File: tb/tb_jht_update_queue.sv
// tb/tb_jht_update_queue.sv - directed self-checking bench for jht_update_queue
module tb_jht_update_queue;
   logic        clk;
   logic        resetn;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic [31:0] stat_resolved;
   logic [31:0] stat_mispredict;
   int          checks;
   int          failures;
   logic [31:0] exp_pc   [5];
   logic [31:0] exp_dest [5];

   jht_update_queue_if uq_if ();

   jht_update_queue #(.DEPTH(4)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .q               (uq_if),
      .mispredict      (mispredict),
      .redirect_pc     (redirect_pc),
      .stat_resolved   (stat_resolved),
      .stat_mispredict (stat_mispredict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] dest,
                        input logic hit, input logic [31:0] pred);
      uq_if.exe_valid    = v;
      uq_if.exe_pc       = pc;
      uq_if.exe_dest     = dest;
      uq_if.exe_pred_hit = hit;
      uq_if.exe_pred_pc  = pred;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      resetn   = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      uq_if.upd_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_mispredict", {31'd0, mispredict}, 32'd0);
      check("rst_redirect", redirect_pc, 32'd0);
      check("rst_upd_valid", {31'd0, uq_if.upd_valid}, 32'd0);
      check("rst_exe_ready", {31'd0, uq_if.exe_ready}, 32'd1);
      check("rst_stat_res", stat_resolved, 32'd0);
      check("rst_stat_mis", stat_mispredict, 32'd0);
      resetn = 1'b1;
      tick();

      // missing prediction: redirect plus one table write
      uq_if.upd_ready = 1'b1;
      drive(1'b1, 32'h8000_0010, 32'h8000_0400, 1'b0, 32'h0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      check("t1_mispredict", {31'd0, mispredict}, 32'd1);
      check("t1_redirect", redirect_pc, 32'h8000_0400);
      check("t1_upd_valid", {31'd0, uq_if.upd_valid}, 32'd1);
      check("t1_upd_pc", uq_if.upd_pc, 32'h8000_0010);
      check("t1_upd_dest", uq_if.upd_dest, 32'h8000_0400);
      tick();
      check("t1_drained", {31'd0, uq_if.upd_valid}, 32'd0);
      check("t1_pulse_end", {31'd0, mispredict}, 32'd0);

      // correct prediction: nothing happens
      drive(1'b1, 32'h8000_0010, 32'h8000_0400, 1'b1, 32'h8000_0400);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      check("t2_mispredict", {31'd0, mispredict}, 32'd0);
      check("t2_upd_valid", {31'd0, uq_if.upd_valid}, 32'd0);

      // fill to DEPTH with the table blocked
      uq_if.upd_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         exp_pc[i]   = 32'h8000_1000 + 32'(i * 4);
         exp_dest[i] = 32'h8000_2000 + 32'(i * 16);
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, exp_pc[i], exp_dest[i], 1'b0, 32'h0);
         tick();
         check("t3_fill_mis", {31'd0, mispredict}, 32'd1);
         check("t3_fill_redir", redirect_pc, exp_dest[i]);
         check("t3_fill_ready", {31'd0, uq_if.exe_ready}, (i == 3) ? 32'd0 : 32'd1);
      end
      drive(1'b1, exp_pc[4], exp_dest[4], 1'b0, 32'h0);
      tick();
      check("t3_stall_mis", {31'd0, mispredict}, 32'd0);
      check("t3_stall_ready", {31'd0, uq_if.exe_ready}, 32'd0);
      check("t3_head_pc", uq_if.upd_pc, exp_pc[0]);
      uq_if.upd_ready = 1'b1;
      #1;
      check("t3_ready_same", {31'd0, uq_if.exe_ready}, 32'd0);
      tick();
      check("t3_ready_back", {31'd0, uq_if.exe_ready}, 32'd1);
      check("t3_no_accept", {31'd0, mispredict}, 32'd0);
      check("t3_pc1", uq_if.upd_pc, exp_pc[1]);
      check("t3_dest1", uq_if.upd_dest, exp_dest[1]);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      check("t3_5th_mis", {31'd0, mispredict}, 32'd1);
      check("t3_5th_redir", redirect_pc, exp_dest[4]);
      for (int k = 2; k < 5; k++) begin
         check("t3_drain_valid", {31'd0, uq_if.upd_valid}, 32'd1);
         check("t3_drain_pc", uq_if.upd_pc, exp_pc[k]);
         check("t3_drain_dest", uq_if.upd_dest, exp_dest[k]);
         tick();
      end
      check("t3_empty", {31'd0, uq_if.upd_valid}, 32'd0);

      // duplicate mispredicts: two pulses, one entry
      uq_if.upd_ready = 1'b0;
      drive(1'b1, 32'h8000_0020, 32'h8000_0800, 1'b0, 32'h0);
      tick();
      check("t4_mis1", {31'd0, mispredict}, 32'd1);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      check("t4_mis2", {31'd0, mispredict}, 32'd1);
      check("t4_redir", redirect_pc, 32'h8000_0800);
      check("t4_valid", {31'd0, uq_if.upd_valid}, 32'd1);
      check("t4_pc", uq_if.upd_pc, 32'h8000_0020);
      uq_if.upd_ready = 1'b1;
      tick();
      check("t4_one_entry", {31'd0, uq_if.upd_valid}, 32'd0);
      check("t4_pulse_end", {31'd0, mispredict}, 32'd0);

      // asynchronous reset with three entries queued
      uq_if.upd_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h8000_3000 + 32'(i * 8), 32'h8000_4000 + 32'(i * 8), 1'b0, 32'h0);
         tick();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      check("t5_pre_valid", {31'd0, uq_if.upd_valid}, 32'd1);
      check("t5_pre_pc", uq_if.upd_pc, 32'h8000_3000);
      #2;
      resetn = 1'b0;
      #1;
      check("t5_async_valid", {31'd0, uq_if.upd_valid}, 32'd0);
      check("t5_async_ready", {31'd0, uq_if.exe_ready}, 32'd1);
      check("t5_async_mis", {31'd0, mispredict}, 32'd0);
      check("t5_async_redir", redirect_pc, 32'd0);
      #2;
      resetn = 1'b1;
      tick();
      check("t5_still_empty", {31'd0, uq_if.upd_valid}, 32'd0);

      // statistics: 5 accepts, 2 mispredicting
      uq_if.upd_ready = 1'b1;
      drive(1'b1, 32'h8000_5000, 32'h8000_6000, 1'b0, 32'h0);
      tick();
      check("t6_mis_a", {31'd0, mispredict}, 32'd1);
      drive(1'b1, 32'h8000_5004, 32'h8000_6004, 1'b1, 32'h8000_6004);
      tick();
      check("t6_ok_a", {31'd0, mispredict}, 32'd0);
      drive(1'b1, 32'h8000_5008, 32'h8000_6008, 1'b1, 32'h8000_6008);
      tick();
      drive(1'b1, 32'h8000_500C, 32'h8000_600C, 1'b1, 32'h8000_7000);
      tick();
      check("t6_mis_b", {31'd0, mispredict}, 32'd1);
      check("t6_redir_b", redirect_pc, 32'h8000_600C);
      drive(1'b1, 32'h8000_5010, 32'h8000_6010, 1'b1, 32'h8000_6010);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      tick();
`ifdef JHT_UQ_STATS_EN
      check("t6_stat_res", stat_resolved, 32'd5);
      check("t6_stat_mis", stat_mispredict, 32'd2);
`else
      check("t6_stat_res", stat_resolved, 32'd0);
      check("t6_stat_mis", stat_mispredict, 32'd0);
`endif
      check("t6_empty", {31'd0, uq_if.upd_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
